// File: rtl/div_ctrl_pkg.sv
// Shared widths, FSM encoding and special-case constants
// for the EX-stage divider sequencing controller.
package div_ctrl_pkg;

   localparam int DATA_BUS        = 32;
   localparam int DOUBLE_DATA_BUS = 64;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_WAIT = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   localparam logic [DATA_BUS-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
   localparam logic [DATA_BUS-1:0] DIV_OVF_QUO  = 32'h8000_0000;
   localparam logic [DATA_BUS-1:0] DIV_MIN_INT  = 32'h8000_0000;
   localparam logic [DATA_BUS-1:0] DIV_NEG_ONE  = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_ctrl_fix.sv
// Remainder/quotient correction: moves a remainder whose sign
// disagrees with the dividend back by one divisor step.
module div_fix
   import div_ctrl_pkg::*;
(
   input  logic [DOUBLE_DATA_BUS-1:0] raw_i,
   input  logic [DATA_BUS-1:0]        n_i,
   input  logic [DATA_BUS-1:0]        d_i,
   output logic [DOUBLE_DATA_BUS-1:0] res_o
);

   logic [DATA_BUS-1:0] r;
   logic [DATA_BUS-1:0] q;
   logic [DATA_BUS-1:0] r_fix;
   logic [DATA_BUS-1:0] q_fix;

   assign r = raw_i[DOUBLE_DATA_BUS-1:DATA_BUS];
   assign q = raw_i[DATA_BUS-1:0];

   always_comb begin
      r_fix = r;
      q_fix = q;
      if ((r != '0) && (r[DATA_BUS-1] != n_i[DATA_BUS-1])) begin
         if (r[DATA_BUS-1] == d_i[DATA_BUS-1]) begin
            r_fix = r - d_i;
            q_fix = q + 32'd1;
         end else begin
            r_fix = r + d_i;
            q_fix = q - 32'd1;
         end
      end
   end

   assign res_o = {r_fix, q_fix};

endmodule

// File: rtl/div_ctrl.sv
// Divider sequencing FSM: latch, settle, capture, fix up,
// with divide-by-zero and overflow short-circuits.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic                       annul_i,
   input  logic [DATA_BUS-1:0]        operand_1_i,
   input  logic [DATA_BUS-1:0]        operand_2_i,
   output logic                       div_en_o,
   output logic [DATA_BUS-1:0]        div_op1_o,
   output logic [DATA_BUS-1:0]        div_op2_o,
   input  logic [DOUBLE_DATA_BUS-1:0] div_result_i,
   output logic [DOUBLE_DATA_BUS-1:0] result_o,
   output logic                       ready_o,
   output logic                       stall_o
);

   div_state_e                 state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic [DATA_BUS-1:0]        op1_q, op1_d;
   logic [DATA_BUS-1:0]        op2_q, op2_d;
   logic [DOUBLE_DATA_BUS-1:0] raw_q, raw_d;
   logic [DOUBLE_DATA_BUS-1:0] result_q, result_d;
   logic [DOUBLE_DATA_BUS-1:0] fixed;
   logic                       accept;

   div_fix u_fix (
      .raw_i (raw_q),
      .n_i   (op1_q),
      .d_i   (op2_q),
      .res_o (fixed)
   );

   assign accept = (state_q == DIV_IDLE) && start_i && !annul_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      raw_d    = raw_q;
      result_d = result_q;
      unique case (state_q)
         DIV_IDLE: begin
            if (accept) begin
               op1_d = operand_1_i;
               op2_d = operand_2_i;
               if (operand_2_i == '0) begin
                  result_d = {operand_1_i, DIV_ZERO_QUO};
                  state_d  = DIV_DONE;
               end else if ((operand_1_i == DIV_MIN_INT) &&
                            (operand_2_i == DIV_NEG_ONE)) begin
                  result_d = {{DATA_BUS{1'b0}}, DIV_OVF_QUO};
                  state_d  = DIV_DONE;
               end else begin
                  cnt_d   = 4'(SETTLE_CYCLES - 1);
                  state_d = DIV_WAIT;
               end
            end
         end
         DIV_WAIT: begin
            if (cnt_q == 4'd0) begin
               raw_d   = div_result_i;
               state_d = DIV_FIX;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DIV_FIX: begin
            result_d = fixed;
            state_d  = DIV_DONE;
         end
         DIV_DONE: begin
            state_d = DIV_IDLE;
         end
      endcase
      // A flush abandons the operation without touching the result
      if (annul_i) begin
         state_d  = DIV_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= DIV_IDLE;
         cnt_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         raw_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         raw_q    <= raw_d;
         result_q <= result_d;
      end
   end

   assign div_en_o  = (state_q == DIV_WAIT);
   assign div_op1_o = op1_q;
   assign div_op2_o = op2_q;
   assign result_o  = result_q;
   assign ready_o   = (state_q == DIV_DONE) && !annul_i;
   assign stall_o   = accept || (state_q == DIV_WAIT) ||
                      (state_q == DIV_FIX);

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl against a
// truncating-division reference with a non-restoring array model.
module tb_div_ctrl;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic [31:0] operand_1_i;
   logic [31:0] operand_2_i;
   logic        div_en_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic [63:0] div_result_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stall_o;

   int total = 0;
   int bad   = 0;

   div_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .operand_1_i  (operand_1_i),
      .operand_2_i  (operand_2_i),
      .div_en_o     (div_en_o),
      .div_op1_o    (div_op1_o),
      .div_op2_o    (div_op2_o),
      .div_result_i (div_result_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stall_o      (stall_o)
   );

   always #5 clk = ~clk;

   // One division; mid_cyc > 0 re-presents start with new operands then.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] raw, input logic [63:0] exp_res,
                         input int exp_lat, input int exp_en,
                         input int mid_cyc, input string nm);
      int seen;
      int en;
      @(negedge clk);
      start_i = 1'b1;
      operand_1_i = a;
      operand_2_i = b;
      div_result_i = raw;
      #1;
      total++;
      if (stall_o !== 1'b1) begin
         bad++;
         $display("FAIL %s stall@0 got=%b want=1", nm, stall_o);
      end
      seen = 0;
      en = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (k == mid_cyc) begin
            start_i = 1'b1;
            operand_1_i = ~a;
            operand_2_i = b + 32'd3;
         end
         #1;
         if (div_en_o === 1'b1) en++;
         if (k <= exp_lat) begin
            total++;
            if (stall_o !== (k < exp_lat)) begin
               bad++;
               $display("FAIL %s stall@%0d got=%b want=%b",
                        nm, k, stall_o, (k < exp_lat));
            end
         end
         if (ready_o === 1'b1) begin
            total++;
            if (seen != 0) begin
               bad++;
               $display("FAIL %s extra_ready@%0d got=1 want=0", nm, k);
            end else begin
               seen = 1;
               if (k != exp_lat) begin
                  bad++;
                  $display("FAIL %s latency got=%0d want=%0d",
                           nm, k, exp_lat);
               end
               total++;
               if (result_o !== exp_res) begin
                  bad++;
                  $display("FAIL %s result got=%h want=%h",
                           nm, result_o, exp_res);
               end
            end
         end
      end
      start_i = 1'b0;
      total++;
      if (seen == 0) begin
         bad++;
         $display("FAIL %s timeout got=no_ready want=ready", nm);
      end
      total++;
      if (en != exp_en) begin
         bad++;
         $display("FAIL %s div_en_cycles got=%0d want=%0d",
                  nm, en, exp_en);
      end
      total++;
      if (div_op1_o !== a || div_op2_o !== b) begin
         bad++;
         $display("FAIL %s ops got=%h/%h want=%h/%h",
                  nm, div_op1_o, div_op2_o, a, b);
      end
      total++;
      if (result_o !== exp_res) begin
         bad++;
         $display("FAIL %s result_hold got=%h want=%h",
                  nm, result_o, exp_res);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_i = 1'b0;
      annul_i = 1'b0;
      operand_1_i = '0;
      operand_2_i = '0;
      div_result_i = '0;
      #12;
      total++;
      if ({div_en_o, ready_o, stall_o} !== 3'b000 ||
          div_op1_o !== '0 || div_op2_o !== '0 || result_o !== '0) begin
         bad++;
         $display("FAIL reset got=%b%b%b %h %h %h want=000 0 0 0",
                  div_en_o, ready_o, stall_o, div_op1_o, div_op2_o,
                  result_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_op(32'd100, 32'd7, {32'd2, 32'd14}, {32'd2, 32'd14},
             S + 2, S, 0, "pos");
      run_op(-32'sd100, 32'd7, {32'd5, 32'hFFFF_FFF1},
             {32'hFFFF_FFFE, 32'hFFFF_FFF2}, S + 2, S, 0, "neg");
      run_op(32'd7, 32'd0, 64'hDEAD_BEEF_0000_0001,
             {32'd7, 32'hFFFF_FFFF}, 1, 0, 0, "divzero");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
             {32'd0, 32'h8000_0000}, 1, 0, 0, "ovf");
   endtask

   task automatic test_annul();
      @(negedge clk);
      start_i = 1'b1;
      operand_1_i = 32'd100;
      operand_2_i = 32'd7;
      div_result_i = {32'd2, 32'd14};
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b1;
      #1;
      total++;
      if (ready_o !== 1'b0) begin
         bad++;
         $display("FAIL annul_ready got=%b want=0", ready_o);
      end
      @(negedge clk);
      annul_i = 1'b0;
      #1;
      total++;
      if (stall_o !== 1'b0 || div_en_o !== 1'b0) begin
         bad++;
         $display("FAIL annul_idle stall/en got=%b%b want=00",
                  stall_o, div_en_o);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         total++;
         if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_noready got=%b want=0", ready_o);
         end
      end
      run_op(32'd100, 32'd7, {32'd2, 32'd14}, {32'd2, 32'd14},
             S + 2, S, 0, "after_annul");
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      start_i = 1'b1;
      operand_1_i = 32'd55;
      operand_2_i = 32'd4;
      div_result_i = {32'd3, 32'd13};
      for (int k = 1; k <= S + 1; k++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      rst = 1'b1;
      #1;
      total++;
      if ({div_en_o, ready_o, stall_o} !== 3'b000 ||
          div_op1_o !== '0 || div_op2_o !== '0 || result_o !== '0) begin
         bad++;
         $display("FAIL rst_fix got=%b%b%b %h %h %h want=000 0 0 0",
                  div_en_o, ready_o, stall_o, div_op1_o, div_op2_o,
                  result_o);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         total++;
         if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_noready got=%b want=0", ready_o);
         end
      end
   endtask

   task automatic test_ignored_start();
      run_op(32'd100, 32'd7, {32'd2, 32'd14}, {32'd2, 32'd14},
             S + 2, S, 2, "start_in_wait");
   endtask

   task automatic test_random();
      logic signed [31:0] sa, sb, q, r, ad, sg;
      logic [63:0] raw;
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) begin
            sa = $urandom;
            sb = $urandom;
         end else begin
            sa = 32'($urandom_range(2000)) - 32'd1000;
            sb = 32'($urandom_range(60)) - 32'd30;
         end
         if (sb == 0 || (sa == 32'sh8000_0000 && sb == -32'sd1))
            sb = 32'sd9;
         q = sa / sb;
         r = sa % sb;
         raw = {r, q};
         // The array may leave the remainder one divisor step past zero
         if (r != 0 && $urandom_range(1) == 1) begin
            ad = sb[31] ? -sb : sb;
            sg = sb[31] ? -32'sd1 : 32'sd1;
            if (!sa[31]) raw = {r - ad, q + sg};
            else         raw = {r + ad, q - sg};
         end
         run_op(sa, sb, raw, {r, q}, S + 2, S, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_annul();
      test_rst_mid();
      test_ignored_start();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
